// File: rtl/arp_pkg.sv
// rtl/arp_pkg.sv - ARP/Ethernet constants, FSM state type and frame word map for arp_frame_builder
package arp_pkg;

  localparam logic [15:0] ETHERTYPE_ARP = 16'h0806;
  localparam logic [15:0] HTYPE_ETH     = 16'h0001;
  localparam logic [15:0] PTYPE_IPV4    = 16'h0800;
  localparam logic [15:0] HLEN_PLEN     = 16'h0604;
  localparam logic [15:0] OPER_REQ      = 16'h0001;
  localparam logic [15:0] OPER_REP      = 16'h0002;
  localparam logic [47:0] BCAST_MAC     = 48'hFFFF_FFFF_FFFF;

  localparam int unsigned NW_BASE = 11;
  localparam int unsigned NW_PAD  = 15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_RDY,
    S_WRITE,
    S_WAIT_SEND,
    S_WAIT_DONE,
    S_DONE,
    S_ERR
  } state_t;

  // Indices past W10 fall to the default and yield the zero padding words.
  function automatic logic [31:0] arp_word(
    input logic [3:0]  idx,
    input logic        op,
    input logic [47:0] src_mac,
    input logic [31:0] src_ip,
    input logic [47:0] tgt_mac,
    input logic [31:0] tgt_ip
  );
    logic [47:0] dst;
    logic [47:0] tha;
    logic [15:0] oper;
    dst  = op ? tgt_mac : BCAST_MAC;
    tha  = op ? tgt_mac : 48'h0;
    oper = op ? OPER_REP : OPER_REQ;
    case (idx)
      4'd0:    arp_word = dst[47:16];
      4'd1:    arp_word = {dst[15:0], src_mac[47:32]};
      4'd2:    arp_word = src_mac[31:0];
      4'd3:    arp_word = {ETHERTYPE_ARP, HTYPE_ETH};
      4'd4:    arp_word = {PTYPE_IPV4, HLEN_PLEN};
      4'd5:    arp_word = {oper, src_mac[47:32]};
      4'd6:    arp_word = src_mac[31:0];
      4'd7:    arp_word = src_ip;
      4'd8:    arp_word = tha[47:16];
      4'd9:    arp_word = {tha[15:0], tgt_ip[31:16]};
      4'd10:   arp_word = {tgt_ip[15:0], 16'h0000};
      default: arp_word = 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/arp_frame_builder.sv
// rtl/arp_frame_builder.sv - streams one Ethernet/ARP frame into an ethernet_module TX port, then sends it
// ARP_PAD_EN: when defined, appends four zero words so the frame reaches the 60-byte minimum.
module arp_frame_builder
  import arp_pkg::*;
#(
  parameter int              TO_W           = 24,
  parameter logic [TO_W-1:0] TIMEOUT_CYCLES = 24'hFFFFFF
) (
  input  logic        clk_100_mhz,
  input  logic        rst_n,
  input  logic        start,
  input  logic        op,
  input  logic [47:0] src_mac,
  input  logic [31:0] src_ip,
  input  logic [47:0] tgt_mac,
  input  logic [31:0] tgt_ip,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] tx_data_in,
  output logic        tx_valid,
  input  logic        tx_ready_to_write,
  input  logic        tx_ready_to_send,
  output logic        tx_send,
  input  logic        tx_done
);

`ifdef ARP_PAD_EN
  localparam int unsigned NW = NW_PAD;
`else
  localparam int unsigned NW = NW_BASE;
`endif

  localparam logic [3:0]      LAST_IDX = 4'(NW - 1);
  localparam logic [TO_W-1:0] TO_ONE   = {{(TO_W-1){1'b0}}, 1'b1};
  localparam logic [TO_W-1:0] TO_LAST  = TIMEOUT_CYCLES - TO_ONE;

  state_t          state;
  state_t          state_n;
  logic [3:0]      word_idx;
  logic [TO_W-1:0] to_cnt;

  logic            op_q;
  logic [47:0]     src_mac_q;
  logic [31:0]     src_ip_q;
  logic [47:0]     tgt_mac_q;
  logic [31:0]     tgt_ip_q;

  always_ff @(posedge clk_100_mhz or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: begin
        if (start) state_n = S_WAIT_RDY;
      end
      S_WAIT_RDY: begin
        if (tx_ready_to_write)      state_n = S_WRITE;
        else if (to_cnt == TO_LAST) state_n = S_ERR;
      end
      S_WRITE: begin
        if (word_idx == LAST_IDX) state_n = S_WAIT_SEND;
      end
      S_WAIT_SEND: begin
        if (tx_ready_to_send) state_n = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        // A completion in the expiry cycle still counts as success.
        if (tx_done)                state_n = S_DONE;
        else if (to_cnt == TO_LAST) state_n = S_ERR;
      end
      S_DONE:  state_n = S_IDLE;
      S_ERR:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    tx_valid   = 1'b0;
    tx_send    = 1'b0;
    tx_data_in = 32'h0;
    case (state)
      S_WAIT_RDY:  busy = 1'b1;
      S_WRITE: begin
        busy       = 1'b1;
        tx_valid   = 1'b1;
        tx_data_in = arp_word(word_idx, op_q, src_mac_q, src_ip_q, tgt_mac_q, tgt_ip_q);
      end
      S_WAIT_SEND: begin
        busy    = 1'b1;
        tx_send = tx_ready_to_send;
      end
      S_WAIT_DONE: busy  = 1'b1;
      S_DONE:      done  = 1'b1;
      S_ERR:       error = 1'b1;
      default: ;
    endcase
  end

  // Request fields are held from the accepted start so the caller may change its inputs freely.
  always_ff @(posedge clk_100_mhz or negedge rst_n) begin
    if (!rst_n) begin
      word_idx  <= 4'd0;
      to_cnt    <= '0;
      op_q      <= 1'b0;
      src_mac_q <= 48'h0;
      src_ip_q  <= 32'h0;
      tgt_mac_q <= 48'h0;
      tgt_ip_q  <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            word_idx  <= 4'd0;
            to_cnt    <= '0;
            op_q      <= op;
            src_mac_q <= src_mac;
            src_ip_q  <= src_ip;
            tgt_mac_q <= tgt_mac;
            tgt_ip_q  <= tgt_ip;
          end
        end
        S_WAIT_RDY:  to_cnt   <= to_cnt + TO_ONE;
        S_WRITE:     word_idx <= word_idx + 4'd1;
        S_WAIT_SEND: to_cnt   <= '0;
        S_WAIT_DONE: to_cnt   <= to_cnt + TO_ONE;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_arp_frame_builder.sv
// tb/tb_arp_frame_builder.sv - directed self-checking bench for arp_frame_builder
module tb_arp_frame_builder;

  localparam int TO = 16;
`ifdef ARP_PAD_EN
  localparam int NW = 15;
`else
  localparam int NW = 11;
`endif

  localparam logic [31:0] REQ_W [0:10] = '{
    32'hFFFFFFFF, 32'hFFFF88E3, 32'h56789ABC, 32'h08060001, 32'h08000604, 32'h000188E3,
    32'h56789ABC, 32'hA9FE1032, 32'h00000000, 32'h0000C0A8, 32'h01010000};
  localparam logic [31:0] REP_W [0:10] = '{
    32'h00112233, 32'h445588E3, 32'h56789ABC, 32'h08060001, 32'h08000604, 32'h000288E3,
    32'h56789ABC, 32'hA9FE1032, 32'h00112233, 32'h4455C0A8, 32'h01010000};

  logic        clk_100_mhz = 1'b0;
  logic        rst_n;
  logic        start;
  logic        op;
  logic [47:0] src_mac;
  logic [31:0] src_ip;
  logic [47:0] tgt_mac;
  logic [31:0] tgt_ip;
  logic        busy;
  logic        done;
  logic        error;
  logic [31:0] tx_data_in;
  logic        tx_valid;
  logic        tx_ready_to_write;
  logic        tx_ready_to_send;
  logic        tx_send;
  logic        tx_done;

  int n_checks = 0;
  int n_errors = 0;
  int send_cnt = 0;
  int done_cnt = 0;
  int err_cnt  = 0;

  logic [31:0] got_w [0:15];
  int          got_n;
  logic        idle_data_bad;

  always #5 clk_100_mhz = ~clk_100_mhz;

  arp_frame_builder #(.TO_W(24), .TIMEOUT_CYCLES(24'd16)) dut (
    .clk_100_mhz       (clk_100_mhz),
    .rst_n             (rst_n),
    .start             (start),
    .op                (op),
    .src_mac           (src_mac),
    .src_ip            (src_ip),
    .tgt_mac           (tgt_mac),
    .tgt_ip            (tgt_ip),
    .busy              (busy),
    .done              (done),
    .error             (error),
    .tx_data_in        (tx_data_in),
    .tx_valid          (tx_valid),
    .tx_ready_to_write (tx_ready_to_write),
    .tx_ready_to_send  (tx_ready_to_send),
    .tx_send           (tx_send),
    .tx_done           (tx_done)
  );

  always @(posedge clk_100_mhz) begin
    if (tx_send) send_cnt++;
    if (done)    done_cnt++;
    if (error)   err_cnt++;
  end

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_100_mhz);
    #2;
  endtask

  function automatic logic [31:0] exp_word(input logic is_rep, input int i);
    if (i > 10) return 32'h0;
    return is_rep ? REP_W[i] : REQ_W[i];
  endfunction

  // Inputs are scrambled right after the start edge to prove the fields were latched.
  task automatic start_frame(input logic is_rep);
    op      = is_rep;
    src_mac = 48'h88E3_5678_9ABC;
    src_ip  = 32'hA9FE_1032;
    tgt_mac = is_rep ? 48'h0011_2233_4455 : 48'hDEAD_BEEF_0001;
    tgt_ip  = 32'hC0A8_0101;
    start   = 1'b1;
    step();
    start   = 1'b0;
    op      = ~is_rep;
    src_mac = 48'h0;
    src_ip  = 32'h0;
    tgt_mac = 48'hFFFF_FFFF_FFFF;
    tgt_ip  = 32'h0;
  endtask

  task automatic capture(input int restart_at, input int reset_at, input logic done_during);
    got_n         = 0;
    idle_data_bad = 1'b0;
    tx_done       = done_during;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (tx_valid) begin
        if (got_n == reset_at) begin
          rst_n = 1'b0;
          #1;
          check("rst_tx_valid", 48'(tx_valid), 48'd0);
          check("rst_tx_data", 48'(tx_data_in), 48'd0);
          break;
        end
        if (got_n < 16) got_w[got_n] = tx_data_in;
        got_n++;
        start = (got_n - 1 == restart_at);
      end else begin
        if (tx_data_in !== 32'h0) idle_data_bad = 1'b1;
        start = 1'b0;
        if (got_n > 0) break;
      end
      step();
    end
    start   = 1'b0;
    tx_done = 1'b0;
  endtask

  task automatic compare_frame(input logic is_rep, input string tag);
    check({tag, "_nwords"}, 48'(got_n), 48'(NW));
    for (int i = 0; i < NW && i < got_n; i++)
      check($sformatf("%s_w%0d", tag, i), 48'(got_w[i]), 48'(exp_word(is_rep, i)));
    check({tag, "_idle_data"}, 48'(idle_data_bad), 48'd0);
  endtask

  task automatic finish_frame(input int send_delay, input int done_delay, input logic restart);
    int sb;
    int db;
    sb = send_cnt;
    db = done_cnt;
    tx_ready_to_send = 1'b0;
    for (int i = 0; i < send_delay; i++) step();
    check("send_early", 48'(send_cnt - sb), 48'd0);
    check("busy_wait_send", 48'(busy), 48'd1);
    tx_ready_to_send = 1'b1;
    #1;
    check("tx_send_pulse", 48'(tx_send), 48'd1);
    step();
    #1;
    check("tx_send_once", 48'(tx_send), 48'd0);
    tx_ready_to_send = 1'b0;
    start = restart;
    step();
    start = 1'b0;
    for (int i = 0; i < done_delay; i++) step();
    check("done_early", 48'(done_cnt - db), 48'd0);
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    #1;
    check("done_pulse", 48'(done), 48'd1);
    check("busy_in_done", 48'(busy), 48'd0);
    step();
    check("done_once", 48'(done), 48'd0);
    step();
    check("no_queued_start", 48'(busy), 48'd0);
    check("send_count", 48'(send_cnt - sb), 48'd1);
    check("done_count", 48'(done_cnt - db), 48'd1);
  endtask

  initial begin
    int eb;
    int db;
    logic bad;
    rst_n = 1'b0;
    start = 1'b0;
    op = 1'b0;
    src_mac = 48'h0;
    src_ip = 32'h0;
    tgt_mac = 48'h0;
    tgt_ip = 32'h0;
    tx_ready_to_write = 1'b0;
    tx_ready_to_send = 1'b0;
    tx_done = 1'b0;
    repeat (3) step();
    check("rst_busy", 48'(busy), 48'd0);
    check("rst_done", 48'(done), 48'd0);
    check("rst_error", 48'(error), 48'd0);
    check("rst_valid", 48'(tx_valid), 48'd0);
    check("rst_data", 48'(tx_data_in), 48'd0);
    check("rst_send", 48'(tx_send), 48'd0);
    rst_n = 1'b1;
    step();

    // ARP request, tgt_mac garbage must not leak into the frame
    tx_ready_to_write = 1'b1;
    start_frame(1'b0);
    check("req_busy", 48'(busy), 48'd1);
    capture(-1, -1, 1'b0);
    compare_frame(1'b0, "req");
    finish_frame(3, 2, 1'b0);

    // ARP reply with tx_done held high through WRITE
    db = done_cnt;
    start_frame(1'b1);
    capture(-1, -1, 1'b1);
    check("early_tx_done_ignored", 48'(done_cnt - db), 48'd0);
    compare_frame(1'b1, "rep");
    finish_frame(0, 4, 1'b0);

    // start re-pulsed during WRITE and during WAIT_DONE
    start_frame(1'b0);
    capture(3, -1, 1'b0);
    compare_frame(1'b0, "restart");
    finish_frame(1, 3, 1'b1);

    // timeout in WAIT_DONE
    eb = err_cnt;
    db = done_cnt;
    start_frame(1'b0);
    capture(-1, -1, 1'b0);
    tx_ready_to_send = 1'b1;
    #1;
    check("wd_tx_send", 48'(tx_send), 48'd1);
    step();
    tx_ready_to_send = 1'b0;
    bad = 1'b0;
    for (int k = 1; k < TO; k++) begin
      step();
      if (error || !busy) bad = 1'b1;
    end
    check("wd_quiet", 48'(bad), 48'd0);
    step();
    check("wd_error", 48'(error), 48'd1);
    check("wd_busy", 48'(busy), 48'd0);
    step();
    check("wd_error_once", 48'(err_cnt - eb), 48'd1);
    check("wd_no_done", 48'(done_cnt - db), 48'd0);

    // timeout in WAIT_RDY
    tx_ready_to_write = 1'b0;
    eb = err_cnt;
    start_frame(1'b0);
    check("wr_busy", 48'(busy), 48'd1);
    bad = 1'b0;
    for (int k = 1; k < TO; k++) begin
      step();
      if (error || tx_valid || !busy) bad = 1'b1;
    end
    check("wr_quiet", 48'(bad), 48'd0);
    step();
    check("wr_error", 48'(error), 48'd1);
    check("wr_busy_low", 48'(busy), 48'd0);
    step();
    check("wr_error_once", 48'(err_cnt - eb), 48'd1);

    // reset asserted while word 5 is on the bus, then a clean frame
    tx_ready_to_write = 1'b1;
    db = done_cnt;
    start_frame(1'b0);
    capture(-1, 5, 1'b0);
    step();
    step();
    check("rst_mid_busy", 48'(busy), 48'd0);
    check("rst_mid_no_done", 48'(done_cnt - db), 48'd0);
    rst_n = 1'b1;
    step();
    start_frame(1'b0);
    capture(-1, -1, 1'b0);
    compare_frame(1'b0, "post_rst");
    finish_frame(2, 1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/arp_frame_builder.md
Name: arp_frame_builder

Overview:
- Upstream feeder for one ethernet_module TX port.
- On a start pulse, the block latches the ARP fields. It streams a complete Ethernet/ARP frame (header plus ARP payload, no FCS) as 32-bit words into the TX write interface, then fires tx_send.
- It waits for tx_done and reports either completion or a timeout.
- It replaces hand-coded word-by-word ARP state machines in board test tops.

Parameters:
- TIMEOUT_CYCLES, 24'hFFFFFF: clk_100_mhz cycles allowed in WAIT_RDY and in WAIT_DONE before the error path.
- TO_W, 24: width of the timeout counter.

Ports:
- clk_100_mhz  in  1  sole clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; honoured only in IDLE
- op  in  1  0 = request (oper 0001), 1 = reply (oper 0002)
- src_mac  in  48  sender MAC
- src_ip  in  32  sender IP
- tgt_mac  in  48  target MAC; used only for replies
- tgt_ip  in  32  target IP
- busy  out  1  high from the cycle after an accepted start until done or error is pulsed
- done  out  1  one-cycle pulse: frame sent
- error  out  1  one-cycle pulse: timeout
- tx_data_in  out  32  frame word; 0 whenever tx_valid is low
- tx_valid  out  1  tx_data_in is valid this cycle
- tx_ready_to_write  in  1  from ethernet_module
- tx_ready_to_send  in  1  from ethernet_module
- tx_send  out  1  one-cycle send pulse
- tx_done  in  1  from ethernet_module

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Asynchronous assert, synchronous deassert handled by the top.
- IDLE: on start, latch op, src_mac, src_ip, tgt_mac, tgt_ip; clear word_idx and the timeout counter; go to WAIT_RDY. Inputs may change after the latch.
- WAIT_RDY: when tx_ready_to_write = 1, go to WRITE. Timeout counter increments each cycle; reaching TIMEOUT_CYCLES-1 leads to ERR.
- WRITE: tx_valid = 1 with one word per cycle, no stalls; ethernet_module accepts every valid cycle.
  - word_idx increments 0..NW-1.
  - After the last word, tx_valid drops to 0 and the block goes to WAIT_SEND.
- Word map, MSB first. D = FFFF_FFFF_FFFF for a request, tgt_mac for a reply. T = 0 for a request, tgt_mac for a reply.
  - W0 = D[47:16]
  - W1 = {D[15:0], src_mac[47:32]}
  - W2 = src_mac[31:0]
  - W3 = 0806_0001
  - W4 = 0800_0604
  - W5 = {oper, src_mac[47:32]}
  - W6 = src_mac[31:0]
  - W7 = src_ip
  - W8 = T[47:16]
  - W9 = {T[15:0], tgt_ip[31:16]}
  - W10 = {tgt_ip[15:0], 0000}
- NW = 11 (see optional feature).
- WAIT_SEND: when tx_ready_to_send = 1, drive tx_send = 1 for exactly one cycle and go to WAIT_DONE with the timeout counter cleared. No timeout applies in this state.
- WAIT_DONE: tx_done = 1 leads to DONE. Timeout leads to ERR. A tx_done arriving in the same cycle as expiry wins.
- DONE / ERR: pulse done / error for one cycle, busy = 0 in that cycle, return to IDLE.
- start outside IDLE is ignored and not queued.
- tx_done seen in IDLE, WAIT_RDY or WRITE is ignored.
- Reset mid-frame: tx_valid and tx_send drop immediately; no partial completion pulse is produced.

Optional Feature:
- Macro ARP_PAD_EN.
- Defined: NW = 15. W11..W14 = 0, padding the frame to the 60-byte Ethernet minimum before FCS.
- Undefined: NW = 11 (44 bytes); ethernet_module is responsible for any padding.

Decomposition:
- Package arp_pkg:
  - ETHERTYPE_ARP = 16'h0806, HTYPE_ETH = 16'h0001, PTYPE_IPV4 = 16'h0800, HLEN_PLEN = 16'h0604
  - OPER_REQ = 16'h0001, OPER_REP = 16'h0002
  - BCAST_MAC = 48'hFFFF_FFFF_FFFF
  - NW_BASE = 11, NW_PAD = 15
  - state enum
- The word map is a pure function in the package, not a sub-module. No sub-module is needed.

Test Plan:
- Request: src_mac 88E3_56789ABC, src_ip A9FE1032, tgt_ip C0A80101, ready_to_write held high.
  - Words FFFFFFFF, FFFF88E3, 56789ABC, 08060001, 08000604, 000188E3, 56789ABC, A9FE1032, 00000000, 000C0A8, 01010000 on 11 consecutive cycles.
  - Then tx_send pulses once ready_to_send = 1; tx_done leads to done one cycle later.
- Reply with tgt_mac 0011_22334455: W0 = 00112233, W1 = 445588E3, W5 = 000288E3, W8 = 00112233, W9 = 4455C0A8.
- ready_to_write held low with TIMEOUT_CYCLES = 16: no tx_valid; error pulses 16 cycles after busy rises; busy = 0.
- start re-pulsed during WRITE and in WAIT_DONE: no change to the word stream; exactly one tx_send and one done.
- rst_n asserted at word 5: tx_valid drops in the same cycle, no done; a following start produces a full clean frame.
- ARP_PAD_EN defined: 15 valid words, last four 00000000, then tx_send.
